// File: rtl/inv_char_sequencer.sv
// Sequencer that toggles the inverter input and measures the synchronized response delay per edge.
// Optional min_delay tracking is enabled by defining INV_CHAR_MIN_EN.
module inv_char_sequencer #(
  parameter int unsigned NUM_EDGES = 16,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             resp_in,
  output logic             stim,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] last_delay,
  output logic [CNT_W-1:0] max_delay,
  output logic [4:0]       edge_cnt
`ifdef INV_CHAR_MIN_EN
  ,
  output logic [CNT_W-1:0] min_delay
`endif
);

  typedef enum logic [2:0] {StIdle, StSettle, StDrive, StWaitResp, StDone} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [4:0]       NumEdgesVal = 5'(NUM_EDGES);

  state_e           state_q, state_d;
  logic             stim_q, stim_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [4:0]       edge_q, edge_d;
  logic             resp_meta_q, resp_s_q;
`ifdef INV_CHAR_MIN_EN
  logic [CNT_W-1:0] min_q, min_d;
`endif

  logic             match;
  logic [CNT_W-1:0] timer_inc;
  logic [4:0]       edge_inc;

  assign match     = (resp_s_q == ~stim_q);
  assign timer_inc = (timer_q == CntMax) ? timer_q : timer_q + 1'b1;
  assign edge_inc  = edge_q + 5'd1;

  // stim toggles on entry to DRIVE, so the DRIVE cycle is part of the measured delay
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    done_d  = 1'b0;
    fail_d  = fail_q;
    timer_d = timer_q;
    last_d  = last_q;
    max_d   = max_q;
    edge_d  = edge_q;
`ifdef INV_CHAR_MIN_EN
    min_d   = min_q;
`endif
    if (!ena) begin
      state_d = StIdle;
      stim_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stim_d = 1'b0;
          if (start) begin
            state_d = StSettle;
            fail_d  = 1'b0;
            last_d  = '0;
            max_d   = '0;
            edge_d  = '0;
            timer_d = '0;
`ifdef INV_CHAR_MIN_EN
            min_d   = '1;
`endif
          end
        end
        StSettle: begin
          if (match) begin
            state_d = StDrive;
            stim_d  = ~stim_q;
          end else if (timer_q == TimeoutVal) begin
            fail_d  = 1'b1;
            state_d = StDone;
          end else begin
            timer_d = timer_inc;
          end
        end
        StDrive: begin
          timer_d = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = StWaitResp;
        end
        StWaitResp: begin
          if (match) begin
            last_d = timer_q;
            if (timer_q > max_q) max_d = timer_q;
`ifdef INV_CHAR_MIN_EN
            if (timer_q < min_q) min_d = timer_q;
`endif
            edge_d = edge_inc;
            if (edge_inc == NumEdgesVal) begin
              state_d = StDone;
            end else begin
              state_d = StDrive;
              stim_d  = ~stim_q;
            end
          end else if (timer_q == TimeoutVal) begin
            fail_d  = 1'b1;
            state_d = StDone;
          end else begin
            timer_d = timer_inc;
          end
        end
        StDone: begin
          stim_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      stim_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      timer_q     <= '0;
      last_q      <= '0;
      max_q       <= '0;
      edge_q      <= '0;
      resp_meta_q <= 1'b0;
      resp_s_q    <= 1'b0;
`ifdef INV_CHAR_MIN_EN
      min_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      max_q       <= max_d;
      edge_q      <= edge_d;
      resp_meta_q <= resp_in;
      resp_s_q    <= resp_meta_q;
`ifdef INV_CHAR_MIN_EN
      min_q       <= min_d;
`endif
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign fail       = fail_q;
  assign last_delay = last_q;
  assign max_delay  = max_q;
  assign edge_cnt   = edge_q;
`ifdef INV_CHAR_MIN_EN
  assign min_delay  = min_q;
`endif

endmodule

// File: tb/tb_inv_char_sequencer.sv
// Scoreboard bench for inv_char_sequencer with a cycle-delayed inverter model on resp_in.
module tb_inv_char_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, resp_in;
  logic       stim, busy, done, fail;
  logic [7:0] last_delay, max_delay;
  logic [4:0] edge_cnt;
`ifdef INV_CHAR_MIN_EN
  logic [7:0] min_delay;
`endif

  inv_char_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .resp_in    (resp_in),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .last_delay (last_delay),
    .max_delay  (max_delay),
    .edge_cnt   (edge_cnt)
`ifdef INV_CHAR_MIN_EN
    ,
    .min_delay  (min_delay)
`endif
  );

  always #5 clk = ~clk;

  // Inverter model: delay 0 is combinational, delay d shows ~stim d clock edges later
  int       delay = 0;
  logic     stuck_en = 1'b0;
  logic     stuck_val = 1'b0;
  logic [7:0] hist;
  logic     resp_model;
  always @(posedge clk) hist <= {hist[6:0], ~stim};
  assign resp_model = (delay == 0) ? ~stim : hist[delay-1];
  assign resp_in    = stuck_en ? stuck_val : resp_model;

  int   toggles = 0;
  int   done_cnt = 0;
  logic stim_prev;
  always @(posedge clk) begin
    if (stim !== stim_prev) toggles <= toggles + 1;
    stim_prev <= stim;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic       fail;
    logic [7:0] last;
    logic [7:0] max;
    logic [4:0] edges;
    logic [7:0] mn;
    int         tog;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for done (bounded), pop the scoreboard entry and compare the run results.
  task automatic wait_done(input bit alt, input int mode, input bit poke);
    bit   got;
    bit   poked;
    int   nxt;
    exp_t e;
    got   = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (alt) begin
        nxt   = int'(edge_cnt) + 1;
        delay = (nxt % 2 == 1) ? 1 : 4;
      end
      if (mode == 2 && edge_cnt == 5'd3 && !stuck_en) begin
        stuck_val = resp_in;
        stuck_en  = 1'b1;
      end
      if (poke && !poked && edge_cnt == 5'd4) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      check_eq("done_seen", 32'(got), 32'd1);
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("fail", 32'(fail), 32'(e.fail));
      check_eq("last_delay", 32'(last_delay), 32'(e.last));
      check_eq("max_delay", 32'(max_delay), 32'(e.max));
      check_eq("edge_cnt", 32'(edge_cnt), 32'(e.edges));
`ifdef INV_CHAR_MIN_EN
      check_eq("min_delay", 32'(min_delay), 32'(e.mn));
`endif
    end
  endtask

  task automatic run(input int d, input bit alt, input int mode, input bit poke, input exp_t e);
    int dn0;
    int tg0;
    delay     = d;
    stuck_en  = (mode == 1);
    stuck_val = 1'b0;
    @(negedge clk);
    dn0   = done_cnt;
    tg0   = toggles;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_on_start", 32'(busy), 32'd1);
    check_eq("fail_cleared", 32'(fail), 32'd0);
    exp_q.push_back(e);
    wait_done(alt, mode, poke);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", 32'(done_cnt - dn0), 32'd1);
    check_eq("stim_toggles", 32'(toggles - tg0), 32'(e.tog));
    stuck_en = 1'b0;
  endtask

  task automatic wait_edge(input logic [4:0] n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (edge_cnt == n) hit = 1'b1;
    end
    if (!hit) check_eq("edge_reached", 32'(hit), 32'd1);
  endtask

  exp_t e_zero, e_five, e_alt, e_stuck0, e_stuck3;
  int   dn0;

  initial begin
    e_zero   = '{fail: 1'b0, last: 8'd2, max: 8'd2, edges: 5'd16, mn: 8'd2,   tog: 16};
    e_five   = '{fail: 1'b0, last: 8'd7, max: 8'd7, edges: 5'd16, mn: 8'd7,   tog: 16};
    e_alt    = '{fail: 1'b0, last: 8'd6, max: 8'd6, edges: 5'd16, mn: 8'd3,   tog: 16};
    e_stuck0 = '{fail: 1'b1, last: 8'd0, max: 8'd0, edges: 5'd0,  mn: 8'd255, tog: 0};
    e_stuck3 = '{fail: 1'b1, last: 8'd3, max: 8'd3, edges: 5'd3,  mn: 8'd3,   tog: 4};

    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_stim", 32'(stim), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fail", 32'(fail), 32'd0);
    check_eq("rst_last", 32'(last_delay), 32'd0);
    check_eq("rst_max", 32'(max_delay), 32'd0);
    check_eq("rst_edges", 32'(edge_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 1'b0, 0, 1'b1, e_zero);   // extra start while busy must be ignored
    run(5, 1'b0, 0, 1'b0, e_five);
    run(1, 1'b1, 0, 1'b0, e_alt);
    run(0, 1'b0, 1, 1'b0, e_stuck0);
    run(1, 1'b0, 2, 1'b0, e_stuck3);
    run(0, 1'b0, 0, 1'b0, e_zero);

    // ena dropped at edge 8
    delay = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(5'd8);
    ena = 1'b0;
    dn0 = done_cnt;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_stim", 32'(stim), 32'd0);
    check_eq("abort_edges", 32'(edge_cnt), 32'd8);
    check_eq("abort_last", 32'(last_delay), 32'd2);
    check_eq("abort_fail", 32'(fail), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    ena = 1'b1;
    @(negedge clk);

    // start held across DONE restarts right after the done cycle
    start = 1'b1;
    exp_q.push_back(e_zero);
    for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge clk);
    check_eq("held_done", 32'(done), 32'd1);
    exp_q.delete();
    @(negedge clk);
    check_eq("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    exp_q.push_back(e_zero);
    wait_done(1'b0, 0, 1'b0);

    // asynchronous reset mid-run
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(5'd5);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_stim", 32'(stim), 32'd0);
    check_eq("arst_edges", 32'(edge_cnt), 32'd0);
    check_eq("arst_last", 32'(last_delay), 32'd0);
    check_eq("arst_max", 32'(max_delay), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
